// File: rtl/uart_pkg.sv
// Shared UART receive types, baud-rate table and divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_OFF  = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned BAUD_NUM     = 13;
  localparam int unsigned BAUD_DEFAULT = 9600;
  localparam int unsigned BAUD_RATES [BAUD_NUM] = '{
    1200, 2400, 4800, 9600, 19200, 28800, 38400,
    57600, 76800, 115200, 230400, 460800, 921600
  };

  function automatic int unsigned baud_rate(input int unsigned sel);
    return (sel < BAUD_NUM) ? BAUD_RATES[4'(sel)] : BAUD_DEFAULT;
  endfunction

  // Rounded clocks per sample tick, clamped to 1 so the tick generator never stalls.
  function automatic int unsigned baud_divisor(input int unsigned clk_freq,
                                               input int unsigned baud,
                                               input int unsigned oversample);
    int unsigned d;
    d = (clk_freq + (baud * oversample) / 2) / (baud * oversample);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: the head word is visible on rd_data while not empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign count   = cnt_q;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; rd_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with parity/frame checks feeding a show-ahead FIFO.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          rx,
  input  logic [3:0]                    baud_sel,
  input  logic [1:0]                    parity_mode,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int unsigned DIV_MAX = baud_divisor(CLK_FREQ, BAUD_RATES[0], OVERSAMPLE);
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);
  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int unsigned DECIDE_IDX = OVERSAMPLE / 2;
`else
  localparam int unsigned DECIDE_IDX = OVERSAMPLE / 2 - 1;
`endif

  logic                 rx_s1, rx_sync, rx_prev;
  rx_state_t            state_q, state_d;
  logic [DIV_W-1:0]     div_tab [16];
  logic [DIV_W-1:0]     div_q, clk_cnt;
  logic [TICK_W-1:0]    tick_cnt;
  parity_mode_t         pmode_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic                 push_q, push_d;
  logic                 frame_err_d, parity_err_d, start_c;
  logic                 tick_c, sample_c, bit_c, rx_fall_c, par_en_c;
  logic                 fifo_full, fifo_empty, fifo_pop_c;

  for (genvar g = 0; g < 16; g++) begin : g_div
    localparam int unsigned DIV = baud_divisor(CLK_FREQ, baud_rate(g), OVERSAMPLE);
    assign div_tab[g] = DIV_W'(DIV);
  end

  assign rx_fall_c  = rx_prev && !rx_sync;
  assign tick_c     = (state_q != ST_IDLE) && (clk_cnt == div_q - DIV_W'(1));
  assign sample_c   = tick_c && (tick_cnt == TICK_W'(DECIDE_IDX));
  assign par_en_c   = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign fifo_pop_c = rd_en && !fifo_empty;
  assign rd_valid   = !fifo_empty;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q;

  // Two early samples held for the vote taken at the decision tick.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vote_q <= 2'b11;
    end else if (tick_c && tick_cnt == TICK_W'(DECIDE_IDX - 2)) begin
      vote_q[0] <= rx_sync;
    end else if (tick_c && tick_cnt == TICK_W'(DECIDE_IDX - 1)) begin
      vote_q[1] <= rx_sync;
    end
  end

  assign bit_c = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync) | (vote_q[1] & rx_sync);
`else
  assign bit_c = rx_sync;
`endif

  // Baud tick generator and per-bit tick counter; both idle at zero outside a frame.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      clk_cnt  <= '0;
      tick_cnt <= '0;
    end else if (state_q == ST_IDLE) begin
      clk_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick_c) begin
      clk_cnt  <= '0;
      tick_cnt <= (tick_cnt == TICK_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TICK_W'(1);
    end else begin
      clk_cnt  <= clk_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    push_d       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    start_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_fall_c) begin
          state_d = ST_START;
          start_c = 1'b1;
        end
      end
      ST_START: begin
        if (sample_c) begin
          if (bit_c) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (sample_c) begin
          shift_d = {bit_c, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_c;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = par_en_c ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample_c) begin
          par_d   = par_q ^ bit_c;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_c) begin
          state_d = ST_IDLE;
          if (!bit_c) begin
            frame_err_d = 1'b1;
          end else if (par_en_c && (par_q != (pmode_q == PAR_ODD))) begin
            parity_err_d = 1'b1;
          end else begin
            push_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_s1      <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      push_q     <= 1'b0;
      div_q      <= '0;
      pmode_q    <= PAR_NONE;
      rx_busy    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_sync    <= rx_s1;
      rx_prev    <= rx_sync;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      push_q     <= push_d;
      rx_busy    <= (state_d != ST_IDLE);
      frame_err  <= frame_err_d;
      parity_err <= parity_err_d;
      overrun    <= push_q && fifo_full && !fifo_pop_c;
      if (start_c) begin
        div_q   <= div_tab[baud_sel];
        pmode_q <= parity_mode_t'(parity_mode);
      end
    end
  end

  // shift_q holds the completed byte for the push cycle; no new shift can occur that soon.
  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .wr_en   (push_q),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of frames plus hand-written FIFO/reset sequences.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_FREQ = 768_000;
  localparam int unsigned DW       = 8;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam int          NV       = 14;

  logic          clk;
  logic          arst_n;
  logic          rx;
  logic [3:0]    baud_sel;
  logic [1:0]    parity_mode;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_count;
  logic          rx_busy;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .DATA_BITS  (DW),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .rx          (rx),
    .baud_sel    (baud_sel),
    .parity_mode (parity_mode),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_count  (fifo_count),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [1:0] pmode;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    int         bit_clks;
    logic       exp_push;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_err    = 0;
  int   ferr_n   = 0;
  int   perr_n   = 0;
  int   ovr_n    = 0;
  logic popped;

  always @(posedge clk) begin
    if (frame_err)  ferr_n++;
    if (parity_err) perr_n++;
    if (overrun)    ovr_n++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Hold rx for a number of clocks; optionally pop once in the first cycle the receiver goes idle.
  task automatic drive_bit(input logic b, input int clocks, input logic pop_sync);
    rx = b;
    for (int c = 0; c < clocks; c++) begin
      @(negedge clk);
      rd_en = 1'b0;
      if (pop_sync && !popped && !rx_busy) begin
        rd_en  = 1'b1;
        popped = 1'b1;
      end
    end
  endtask

  // Full frame plus one idle bit; rate/parity inputs are scrambled after the start bit.
  task automatic send_frame(input logic [3:0] sel, input logic [1:0] pm, input logic [7:0] d,
                            input logic pb, input logic sb, input int bc, input logic pop_sync);
    baud_sel    = sel;
    parity_mode = pm;
    popped      = 1'b0;
    drive_bit(1'b0, bc, 1'b0);
    baud_sel    = ~sel;
    parity_mode = ~pm;
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc, 1'b0);
    if (pm == 2'b01 || pm == 2'b10) drive_bit(pb, bc, 1'b0);
    drive_bit(sb, bc, pop_sync);
    drive_bit(1'b1, bc, 1'b0);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int         f0, p0, o0;
    logic [7:0] d55;
    logic [7:0] exp_b;

    // sel, pmode, data, parity bit, stop bit, clocks/bit, push?, frame_err, parity_err
    vecs[0]  = '{4'd3,  2'b00, 8'hA5, 1'b0, 1'b1, 80,  1'b1, 0, 0};
    vecs[1]  = '{4'd3,  2'b01, 8'h07, 1'b1, 1'b1, 80,  1'b1, 0, 0};
    vecs[2]  = '{4'd3,  2'b01, 8'h07, 1'b0, 1'b1, 80,  1'b0, 0, 1};
    vecs[3]  = '{4'd3,  2'b00, 8'h3C, 1'b0, 1'b0, 80,  1'b0, 1, 0};
    vecs[4]  = '{4'd3,  2'b00, 8'h3D, 1'b0, 1'b1, 80,  1'b1, 0, 0};
    vecs[5]  = '{4'd3,  2'b10, 8'h07, 1'b0, 1'b1, 80,  1'b1, 0, 0};
    vecs[6]  = '{4'd3,  2'b10, 8'h07, 1'b1, 1'b1, 80,  1'b0, 0, 1};
    vecs[7]  = '{4'd3,  2'b11, 8'h5A, 1'b0, 1'b1, 80,  1'b1, 0, 0};
    vecs[8]  = '{4'd3,  2'b01, 8'h07, 1'b0, 1'b0, 80,  1'b0, 1, 0};
    vecs[9]  = '{4'd4,  2'b00, 8'hC3, 1'b0, 1'b1, 48,  1'b1, 0, 0};
    vecs[10] = '{4'd5,  2'b01, 8'h69, 1'b0, 1'b1, 32,  1'b1, 0, 0};
    vecs[11] = '{4'd7,  2'b10, 8'hE1, 1'b1, 1'b1, 16,  1'b1, 0, 0};
    vecs[12] = '{4'd13, 2'b00, 8'h96, 1'b0, 1'b1, 80,  1'b1, 0, 0};
    vecs[13] = '{4'd0,  2'b00, 8'h01, 1'b0, 1'b1, 640, 1'b1, 0, 0};

    arst_n      = 1'b0;
    rx          = 1'b1;
    rd_en       = 1'b0;
    baud_sel    = 4'd3;
    parity_mode = 2'b00;
    popped      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rd_valid",   32'(rd_valid),   32'd0);
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    check("reset rd_data",    32'(rd_data),    32'd0);
    check("reset rx_busy",    32'(rx_busy),    32'd0);
    check("reset errors",     32'({frame_err, parity_err, overrun}), 32'd0);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single frames across parity modes, error cases and baud selections.
    for (int i = 0; i < NV; i++) begin
      f0 = ferr_n;
      p0 = perr_n;
      send_frame(vecs[i].sel, vecs[i].pmode, vecs[i].data, vecs[i].par_bit,
                 vecs[i].stop_bit, vecs[i].bit_clks, 1'b0);
      check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].exp_push));
      check($sformatf("v%0d rd_valid", i),   32'(rd_valid),   32'(vecs[i].exp_push));
      if (vecs[i].exp_push) check($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].data));
      check($sformatf("v%0d frame_err", i),  ferr_n - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d parity_err", i), perr_n - p0, vecs[i].exp_perr);
      pop_one();
      check($sformatf("v%0d drained", i), 32'({rd_valid, fifo_count}), 32'd0);
    end

    // Pop while empty is ignored.
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = 1'b0;
    check("empty pop count", 32'(fifo_count), 32'd0);

    // Fill past capacity: the 17th byte is dropped with one overrun pulse.
    o0 = ovr_n;
    for (int i = 0; i < 17; i++) begin
      send_frame(4'd3, 2'b00, 8'(i), 1'b0, 1'b1, 80, 1'b0);
      if (i == 15) check("fill16 count", 32'(fifo_count), 32'd16);
    end
    check("full count",    32'(fifo_count), 32'd16);
    check("overrun pulse", ovr_n - o0,      32'd1);
    check("full head",     32'(rd_data),    32'h00);

    // Push and pop in the same cycle while full: no overrun, count stays 16.
    send_frame(4'd3, 2'b00, 8'h11, 1'b0, 1'b1, 80, 1'b1);
    check("pushpop popped",  32'(popped),     32'd1);
    check("pushpop count",   32'(fifo_count), 32'd16);
    check("pushpop overrun", ovr_n - o0,      32'd1);
    for (int i = 1; i <= 16; i++) begin
      exp_b = (i == 16) ? 8'h11 : 8'(i);
      check($sformatf("drain %0d", i), 32'(rd_data), 32'(exp_b));
      pop_one();
    end
    check("drain empty", 32'({rd_valid, fifo_count}), 32'd0);

    // False start: short low pulse, receiver gives up at the mid-start sample.
    f0 = ferr_n;
    p0 = perr_n;
    baud_sel    = 4'd3;
    parity_mode = 2'b00;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("false start busy", 32'(rx_busy), 32'd1);
    repeat (40) @(negedge clk);
    check("false start idle",  32'(rx_busy),    32'd0);
    check("false start count", 32'(fifo_count), 32'd0);
    check("false start errs",  (ferr_n - f0) + (perr_n - p0), 32'd0);

    // Reset mid-frame with three bytes queued.
    send_frame(4'd3, 2'b00, 8'h11, 1'b0, 1'b1, 80, 1'b0);
    send_frame(4'd3, 2'b00, 8'h22, 1'b0, 1'b1, 80, 1'b0);
    send_frame(4'd3, 2'b00, 8'h33, 1'b0, 1'b1, 80, 1'b0);
    check("queued count", 32'(fifo_count), 32'd3);
    f0 = ferr_n;
    p0 = perr_n;
    o0 = ovr_n;
    d55 = 8'h55;
    drive_bit(1'b0, 80, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d55[i], 80, 1'b0);
    rx = d55[4];
    repeat (40) @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("midreset rd_valid", 32'(rd_valid),   32'd0);
    check("midreset count",    32'(fifo_count), 32'd0);
    check("midreset rd_data",  32'(rd_data),    32'd0);
    check("midreset busy",     32'(rx_busy),    32'd0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(4'd3, 2'b00, 8'h81, 1'b0, 1'b1, 80, 1'b0);
    check("post reset count", 32'(fifo_count), 32'd1);
    check("post reset data",  32'(rd_data),    32'h81);
    check("post reset errs",  (ferr_n - f0) + (perr_n - p0) + (ovr_n - o0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor receiver for the UART link: oversampled RX deserialiser with selectable baud rate, configurable data width and parity, and a show-ahead receive FIFO. It sits between the synchronised rx pin and the program loader or consumer, which drains bytes by handshake. It adds parity checking, false-start rejection, error reporting and buffering.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
DATA_BITS, 8, data bits per frame (5..9), LSB first.
OVERSAMPLE, 16, sample ticks per bit (even, >=8).
FIFO_DEPTH, 16, receive FIFO entries (power of 2).

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
baud_sel  input  4  rate select: 0..12 = 1200, 2400, 4800, 9600, 19200, 28800, 38400, 57600, 76800, 115200, 230400, 460800, 921600; 13..15 = 9600
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
rd_en  input  1  pop request
rd_data  output  DATA_BITS  FIFO head, valid while rd_valid
rd_valid  output  1  FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
rx_busy  output  1  FSM not in IDLE
frame_err  output  1  one-cycle pulse
parity_err  output  1  one-cycle pulse
overrun  output  1  one-cycle pulse

Behaviour:
- Reset: all outputs 0; rx synchroniser flops reset to 1; FSM IDLE; FIFO empty; tick counter 0.
- rx passes a 2-flop synchroniser. All sampling uses the synchronised value.
- Divisor: (CLK_FREQ + baud*OVERSAMPLE/2) / (baud*OVERSAMPLE), rounded. Examples: 9600 gives 326; 921600 gives 3. Tick generator pulses once per divisor clocks and runs only while rx_busy.
- baud_sel and parity_mode are latched at start detection. Changes mid-frame are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a falling edge of synchronised rx; the sample-tick counter clears.
- START: sample at tick OVERSAMPLE/2-1. If rx = 1, it is a false start: return to IDLE with no error. Otherwise go to DATA.
- DATA: one bit per OVERSAMPLE ticks, each sampled mid-bit, shifted in LSB first. After DATA_BITS bits go to PARITY if parity is enabled, else STOP.
- PARITY: sample mid-bit. Even mode expects the XOR of data and parity bit = 0; odd mode expects 1.
- STOP: sample mid-bit, then go to IDLE immediately, so back-to-back frames are accepted.
  - stop = 0: frame_err pulse, byte discarded.
  - else parity mismatch: parity_err pulse, byte discarded.
  - else push the byte in the cycle after the stop sample; rd_valid is asserted the following cycle.
  - frame_err takes priority over parity_err.
- FIFO is show-ahead:
  - rd_en && rd_valid pops; the next entry appears the next cycle.
  - rd_en while empty is ignored.
  - Push while full and no pop: byte dropped, overrun pulse, contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame aborts the frame at once and empties the FIFO. No error pulses are issued.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN:
- When defined, every bit (start, data, parity, stop) is taken as the 2-of-3 majority of samples at ticks OVERSAMPLE/2-2, -1 and 0. The decision is made at the last of these samples.
- When undefined, the block uses a single sample at tick OVERSAMPLE/2-1.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_t enum
  - rx_state_t enum
  - 13-entry baud rate constant array
  - function baud_divisor(clk_freq, baud, oversample)
- One sub-module, uart_sync_fifo: parametrised width/depth, show-ahead, outputs count/full/empty. The top holds the synchroniser, tick generator, FSM and checks.

Test Plan:
1. baud_sel=0011, parity none, frame 0xA5 (bit time 104.32us) -> rd_valid=1, rd_data=0xA5, fifo_count=1, no error pulses; rd_en for 1 cycle -> rd_valid=0, fifo_count=0.
2. parity_mode=01, data 0x07 with parity bit 1 -> accepted as 0x07. Same data with parity bit 0 -> one parity_err pulse, fifo_count unchanged.
3. Frame 0x3C with stop bit 0 -> one frame_err pulse, nothing pushed. Following valid frame 0x3D -> received.
4. 17 frames 0x00..0x10 without reading, depth 16 -> fifo_count=16, one overrun on 17th. Reading out yields 0x00..0x0F in order.
5. rx low for 2us then high at 9600 -> no push, no error, rx_busy returns to 0 at mid-start sample (~52us).
6. arst_n low during data bit 4 of 0x55 with 3 bytes queued -> all outputs 0, fifo_count=0. After release, frame 0x81 -> rd_data=0x81.
